// File: rtl/telemetry_frame_tx_if.sv
// Telemetry frame transmitter bus: snapshot inputs, request strobe and UART byte handshake.
// Pure wiring, no latency.
// tx_busy from the UART stalls byte issue; send_req is dropped while a frame is in flight.
interface telemetry_frame_tx_if;
  logic [11:0] enc1_pos;
  logic [11:0] enc2_pos;
  logic [7:0]  temperature;
  logic [7:0]  bill_count;
  logic        send_req;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        frame_busy;
  logic        frame_done;

  modport master (
    output enc1_pos, enc2_pos, temperature, bill_count, send_req, tx_busy,
    input  tx_start, tx_data, frame_busy, frame_done
  );

  modport slave (
    input  enc1_pos, enc2_pos, temperature, bill_count, send_req, tx_busy,
    output tx_start, tx_data, frame_busy, frame_done
  );
endinterface

// File: rtl/telemetry_frame_tx.sv
// Telemetry frame transmitter: snapshots encoders/temperature/bill count and sends an ASCII hex line to a UART.
// Latency: send_req to first tx_start is 2 cycles with the UART idle; one byte per tx_busy low period.
// Backpressure: each byte waits for tx_busy low; requests during a frame are dropped. TELEM_CHECKSUM_EN adds an XOR checksum field.
module telemetry_frame_tx #(
  parameter bit ONLY_ON_CHANGE = 1'b1,
  parameter bit HEX_UPPER      = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  telemetry_frame_tx_if.slave bus
);

`ifdef TELEM_CHECKSUM_EN
  localparam int FRAME_LEN = 18;
`else
  localparam int FRAME_LEN = 15;
`endif
  localparam logic [4:0] LAST_IDX = 5'(FRAME_LEN - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND,
    WAIT_ACK,
    WAIT_FREE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [4:0]  idx;
  logic [39:0] snapshot;
  logic [39:0] last_sent;
  logic        sent;
  logic [39:0] live;
  logic        load_en;
  logic        sent_set;
  logic        idx_inc;
  logic        done;
  logic [7:0]  cur_byte;

  assign live = {bus.enc1_pos, bus.enc2_pos, bus.temperature, bus.bill_count};

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) hex_ascii = 8'h30 + {4'h0, n};
    else           hex_ascii = (HEX_UPPER ? 8'h41 : 8'h61) + {4'h0, n} - 8'd10;
  endfunction

  // Bytes 0..12 are the data fields and separators, common to both frame formats.
  function automatic logic [7:0] field_byte(input logic [39:0] s, input logic [4:0] i);
    case (i)
      5'd0:    field_byte = hex_ascii(s[39:36]);
      5'd1:    field_byte = hex_ascii(s[35:32]);
      5'd2:    field_byte = hex_ascii(s[31:28]);
      5'd4:    field_byte = hex_ascii(s[27:24]);
      5'd5:    field_byte = hex_ascii(s[23:20]);
      5'd6:    field_byte = hex_ascii(s[19:16]);
      5'd8:    field_byte = hex_ascii(s[15:12]);
      5'd9:    field_byte = hex_ascii(s[11:8]);
      5'd11:   field_byte = hex_ascii(s[7:4]);
      5'd12:   field_byte = hex_ascii(s[3:0]);
      5'd3, 5'd7, 5'd10: field_byte = 8'h20;
      default: field_byte = 8'h00;
    endcase
  endfunction

`ifdef TELEM_CHECKSUM_EN
  logic [7:0] checksum;

  // XOR of the 13 field bytes, taken from the frozen snapshot so it is stable all frame.
  always_comb begin
    checksum = 8'h00;
    for (int i = 0; i < 13; i++) begin
      checksum = checksum ^ field_byte(snapshot, 5'(i));
    end
  end
`endif

  // Select the byte for the current index; the trailer differs with the checksum option.
  always_comb begin
    cur_byte = 8'h00;
    if (idx < 5'd13) begin
      cur_byte = field_byte(snapshot, idx);
    end else begin
      case (idx)
`ifdef TELEM_CHECKSUM_EN
        5'd13:   cur_byte = 8'h20;
        5'd14:   cur_byte = hex_ascii(checksum[7:4]);
        5'd15:   cur_byte = hex_ascii(checksum[3:0]);
        5'd16:   cur_byte = 8'h0D;
        5'd17:   cur_byte = 8'h0A;
`else
        5'd13:   cur_byte = 8'h0D;
        5'd14:   cur_byte = 8'h0A;
`endif
        default: cur_byte = 8'h00;
      endcase
    end
  end

  // Next-state and per-cycle strobes; a first byte held off by tx_busy at LOAD waits in WAIT_FREE with sent=0.
  always_comb begin
    state_nxt = state;
    load_en   = 1'b0;
    sent_set  = 1'b0;
    idx_inc   = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.send_req && (!ONLY_ON_CHANGE || (live != last_sent))) state_nxt = LOAD;
      end
      LOAD: begin
        load_en   = 1'b1;
        state_nxt = bus.tx_busy ? WAIT_FREE : SEND;
      end
      SEND: begin
        sent_set  = 1'b1;
        state_nxt = WAIT_ACK;
      end
      WAIT_ACK: begin
        state_nxt = WAIT_FREE;
      end
      WAIT_FREE: begin
        if (!bus.tx_busy) begin
          if (!sent) begin
            state_nxt = SEND;
          end else if (idx == LAST_IDX) begin
            done      = 1'b1;
            state_nxt = IDLE;
          end else begin
            idx_inc   = 1'b1;
            state_nxt = SEND;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, index, snapshot and last-sent registers; reset aborts a frame without recording it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= 5'd0;
      snapshot  <= '0;
      last_sent <= '1;
      sent      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load_en) begin
        snapshot <= live;
        idx      <= 5'd0;
        sent     <= 1'b0;
      end
      if (sent_set) sent <= 1'b1;
      if (idx_inc && (idx != LAST_IDX)) idx <= idx + 5'd1;
      if (done) last_sent <= snapshot;
    end
  end

  assign bus.tx_start   = !rst && (state == SEND);
  assign bus.frame_done = !rst && done;
  assign bus.frame_busy = !rst && (state != IDLE);
  assign bus.tx_data    = (!rst && (state == SEND || state == WAIT_ACK || state == WAIT_FREE)) ?
                          cur_byte : 8'h00;

endmodule

// File: doc/telemetry_frame_tx.md
TELEMETRY_FRAME_TX -- requirements
Module: telemetry_frame_tx

Interface
REQ-001 SHALL have parameter ONLY_ON_CHANGE, default 1, meaning a request is honoured only if the new snapshot differs from the last frame sent.
REQ-002 SHALL have parameter HEX_UPPER, default 1, meaning hex digits A-F are emitted as 0x41-0x46; when 0, as 0x61-0x66.
REQ-003 SHALL have port clk, input, 1, the single clock (10 MHz board clock); the only clock domain.
REQ-004 SHALL have port rst, input, 1, synchronous, active-high reset.
REQ-005 SHALL have port enc1_pos, input, 12, encoder 1 position.
REQ-006 SHALL have port enc2_pos, input, 12, encoder 2 position.
REQ-007 SHALL have port temperature, input, 8, 1-wire sensor temperature.
REQ-008 SHALL have port bill_count, input, 8, bill validator accumulated count.
REQ-009 SHALL have port send_req, input, 1, one-cycle frame request strobe.
REQ-010 SHALL have port tx_busy, input, 1, UART transmitter busy.
REQ-011 SHALL have port tx_start, output, 1, one-cycle byte-start strobe to the UART transmitter.
REQ-012 SHALL have port tx_data, output, 8, byte to transmit; stable from tx_start until tx_busy falls.
REQ-013 SHALL have port frame_busy, output, 1, high from snapshot load until the last byte is accepted.
REQ-014 SHALL have port frame_done, output, 1, one-cycle pulse when the last byte's tx_busy falls.

Function
REQ-015 Frame SHALL be 15 ASCII bytes: enc1 3 hex (MSB first), 0x20, enc2 3 hex, 0x20, temperature 2 hex, 0x20, bill_count 2 hex, 0x0D, 0x0A.
REQ-016 FSM states SHALL be IDLE, LOAD, SEND, WAIT_ACK, WAIT_FREE.
REQ-017 IDLE: send_req=1 with ONLY_ON_CHANGE=0, or ONLY_ON_CHANGE=1 and {enc1,enc2,temperature,bill_count} differs from the last-sent register, -> LOAD next cycle; otherwise request dropped.
REQ-018 LOAD: all four inputs captured into a snapshot register in one cycle; byte index cleared to 0; -> SEND. Input changes after LOAD SHALL NOT affect the frame.
REQ-019 SEND: entered only when tx_busy=0; tx_data set to byte[index]; tx_start=1 for exactly one cycle; -> WAIT_ACK.
REQ-020 WAIT_ACK: tx_busy ignored for exactly one cycle (transmitter busy lags start by one cycle); -> WAIT_FREE.
REQ-021 WAIT_FREE: hold until tx_busy=0; then, if index is last, pulse frame_done, copy snapshot into last-sent register, -> IDLE; else index+1, -> SEND.
REQ-022 Latency: send_req to first tx_start SHALL be 2 cycles when tx_busy=0.
REQ-023 send_req while frame_busy=1 SHALL be ignored (no queueing).
REQ-024 Nibble-to-ASCII: 0-9 -> 0x30-0x39; A-F per HEX_UPPER.
REQ-025 Byte index SHALL be 5 bits, never exceeding the last index; no wrap.
REQ-026 If tx_busy=1 when LOAD completes, SEND SHALL wait (stay in WAIT_FREE path) until tx_busy=0.

Reset
REQ-027 rst=1 SHALL force IDLE, tx_start=0, tx_data=0x00, frame_busy=0, frame_done=0, index=0, snapshot=0, last-sent register=all-ones (so first request always sends).
REQ-028 rst mid-frame SHALL abort immediately; no further tx_start; partial frame not recorded as sent.

Configuration
REQ-029 Macro TELEM_CHECKSUM_EN defined: frame SHALL be 18 bytes, inserting 0x20 plus 2 hex digits of the XOR of bytes 0-12 before 0x0D 0x0A.
REQ-030 TELEM_CHECKSUM_EN undefined: frame SHALL be the 15-byte format of REQ-015 with no checksum logic synthesised.

Verification
REQ-031 rst, enc1=0x1A3, enc2=0x0FF, temp=0x19, bill=0x05, send_req, tx_busy modelled as 1 for 20 cycles after each start -> bytes "1A3 0FF 19 05\r\n", one frame_done.
REQ-032 Repeat send_req with identical inputs, ONLY_ON_CHANGE=1 -> no tx_start; change temp to 0x1A, send_req -> full frame "1A3 0FF 1A 05\r\n".
REQ-033 send_req at cycle 3 and again mid-frame; enc1 changed to 0x000 after LOAD -> single frame carrying 0x1A3.
REQ-034 rst asserted after byte 5 accepted -> tx_start stays 0; next send_req with same inputs sends full frame.
REQ-035 HEX_UPPER=0, enc1=0xABC -> first bytes 0x61 0x62 0x63.
REQ-036 TELEM_CHECKSUM_EN, inputs of REQ-031 -> 18 bytes, bytes 13-15 = 0x20 plus XOR of bytes 0-12 in hex, then 0x0D 0x0A.
